// File: rtl/fib_alu_seq.sv
// Fibonacci sequencer driving a combinational 8-bit ALU.
// Adds byte-serially with carry chaining to build WORDS-byte results.
module fib_alu_seq #(
    parameter int WORDS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         n,
    output logic               busy,
    output logic               done,
    output logic [8*WORDS-1:0] fib,
    output logic               overflow,
    output logic [7:0]         alu_left,
    output logic [7:0]         alu_right,
    output logic               alu_status_in,
    output logic [1:0]         alu_opcode,
    input  logic [7:0]         alu_result,
    input  logic               alu_status_out
);

    localparam int W  = 8 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
    localparam logic [1:0] OP_ADD = 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        FINISH
    } state_t;

    state_t        state;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  sum;
    logic [W-1:0]  sum_next;
    logic          carry;
    logic [IW-1:0] idx;
    logic [7:0]    cnt;
    logic          ovf;
    logic          top_ovf;

    assign busy = (state == STEP);
    assign done = (state == FINISH);

    assign alu_left      = busy ? a[8*idx +: 8] : 8'd0;
    assign alu_right     = busy ? b[8*idx +: 8] : 8'd0;
    assign alu_status_in = busy && (idx != '0) && carry;
    assign alu_opcode    = OP_ADD;

    // b for the next iteration includes the byte captured this cycle
    always_comb begin
        sum_next = sum;
        sum_next[8*idx +: 8] = alu_result;
    end

    assign top_ovf = ovf | alu_status_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fib      <= '0;
            overflow <= 1'b0;
            a        <= '0;
            b        <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            cnt      <= 8'd0;
            ovf      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a     <= '0;
                        b     <= W'(1);
                        carry <= 1'b0;
                        idx   <= '0;
                        ovf   <= 1'b0;
                        if (n < 8'd2) begin
                            fib      <= W'(n);
                            overflow <= 1'b0;
                            state    <= FINISH;
                        end else begin
                            cnt   <= n - 8'd1;
                            state <= STEP;
                        end
                    end
                end
                STEP: begin
                    sum   <= sum_next;
                    carry <= alu_status_out;
                    if (idx == LAST) begin
                        ovf <= top_ovf;
                        a   <= b;
                        b   <= sum_next;
                        idx <= '0;
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            fib      <= sum_next;
                            overflow <= top_ovf;
                            state    <= FINISH;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_alu_seq.sv
// Directed bench for fib_alu_seq with a behavioural alu8 model.
// Inputs change and outputs are sampled on the falling edge.
module tb_fib_alu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  n = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] fib;
    logic        overflow;
    logic [7:0]  alu_left;
    logic [7:0]  alu_right;
    logic        alu_status_in;
    logic [1:0]  alu_opcode;
    logic [7:0]  alu_result;
    logic        alu_status_out;

    int checks = 0;
    int failures = 0;

    // values seen on the last iteration of the most recent run
    logic [7:0] lo_left, lo_right, lo_res;
    logic       lo_cout, lo_cin, hi_cin;
    int         busy_seen;
    int         op_bad;

    fib_alu_seq #(.WORDS(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .n              (n),
        .busy           (busy),
        .done           (done),
        .fib            (fib),
        .overflow       (overflow),
        .alu_left       (alu_left),
        .alu_right      (alu_right),
        .alu_status_in  (alu_status_in),
        .alu_opcode     (alu_opcode),
        .alu_result     (alu_result),
        .alu_status_out (alu_status_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [8:0] s;
        s = {1'b0, alu_left} + {1'b0, alu_right}
          + {8'd0, alu_status_in};
        alu_result     = s[7:0];
        alu_status_out = s[8];
    end

    task automatic run(input logic [7:0] nv,
                       input logic [15:0] exp_fib,
                       input logic exp_ovf);
        int cyc;
        int exp_cyc;
        bit got;
        exp_cyc = (nv < 2) ? 1 : 1 + (int'(nv) - 1) * 2;
        busy_seen = 0;
        op_bad = 0;
        got = 0;
        @(negedge clk);
        start = 1'b1;
        n = nv;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc <= 600) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) busy_seen++;
            if (busy && alu_opcode !== 2'd0) op_bad++;
            if (cyc == exp_cyc - 2) begin
                lo_left  = alu_left;
                lo_right = alu_right;
                lo_res   = alu_result;
                lo_cout  = alu_status_out;
                lo_cin   = alu_status_in;
            end
            if (cyc == exp_cyc - 1) hi_cin = alu_status_in;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout n=%0d", nv);
        end else if (cyc != exp_cyc) begin
            failures++;
            $display("FAIL done_cycle n=%0d got=%0d exp=%0d",
                     nv, cyc, exp_cyc);
        end
        checks++;
        if (fib !== exp_fib) begin
            failures++;
            $display("FAIL fib n=%0d got=%h exp=%h",
                     nv, fib, exp_fib);
        end
        checks++;
        if (overflow !== exp_ovf) begin
            failures++;
            $display("FAIL ovf n=%0d got=%b exp=%b",
                     nv, overflow, exp_ovf);
        end
        checks++;
        if (busy_seen != exp_cyc - 1) begin
            failures++;
            $display("FAIL busy_len n=%0d got=%0d exp=%0d",
                     nv, busy_seen, exp_cyc - 1);
        end
        checks++;
        if (op_bad != 0) begin
            failures++;
            $display("FAIL opcode n=%0d bad=%0d exp=0", nv, op_bad);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || fib !== exp_fib) begin
            failures++;
            $display("FAIL done_pulse n=%0d done=%b fib=%h exp=0/%h",
                     nv, done, fib, exp_fib);
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fib !== 16'h0 ||
            overflow !== 1'b0) begin
            failures++;
            $display("FAIL %s_out busy=%b done=%b fib=%h ovf=%b exp=0",
                     tag, busy, done, fib, overflow);
        end
        checks++;
        if (alu_left !== 8'h0 || alu_right !== 8'h0 ||
            alu_status_in !== 1'b0 || alu_opcode !== 2'd0) begin
            failures++;
            $display("FAIL %s_alu l=%h r=%h ci=%b op=%h exp=0",
                     tag, alu_left, alu_right, alu_status_in,
                     alu_opcode);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
    endtask

    task automatic test_small();
        run(8'd0, 16'h0000, 1'b0);
        run(8'd1, 16'h0001, 1'b0);
    endtask

    task automatic test_fib10();
        run(8'd10, 16'h0037, 1'b0);
    endtask

    task automatic test_carry();
        run(8'd14, 16'h0179, 1'b0);
        checks++;
        if (lo_left !== 8'h90 || lo_right !== 8'hE9 ||
            lo_res !== 8'h79 || lo_cout !== 1'b1 ||
            lo_cin !== 1'b0) begin
            failures++;
            $display("FAIL lo_byte l=%h r=%h res=%h co=%b ci=%b exp=90 e9 79 1 0",
                     lo_left, lo_right, lo_res, lo_cout, lo_cin);
        end
        checks++;
        if (hi_cin !== 1'b1) begin
            failures++;
            $display("FAIL hi_cin got=%b exp=1", hi_cin);
        end
    endtask

    task automatic test_overflow();
        run(8'd24, 16'hB520, 1'b0);
        run(8'd25, 16'h2511, 1'b1);
        run(8'd5, 16'h0005, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1;
        n = 8'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        n = 8'd1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start busy=%b done=%b exp=1/0",
                     busy, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        reset = 1'b0;
        run(8'd3, 16'h0002, 1'b0);
    endtask

    initial begin
        test_reset();
        test_small();
        test_fib10();
        test_carry();
        test_overflow();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
